// File: rtl/regfile_pkg.sv
// Shared constants and the write-request bundle for the register-file writeback arbiter.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;

  typedef struct packed {
    logic                    en;
    logic [REG_ADDR_W-1:0]   addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-unit results until a free writeback slot appears.
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow wraps naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered long-unit results.
// Define REGFILE_WB_BYPASS_EN to let a result cut through to the port when the FIFO is empty and the port is idle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW = $clog2(BUF_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wr_en,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wdata,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_waddr,
  input  logic [XLEN-1:0]       lu_wdata,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd_dec,
  output logic                  stall,
  output logic                  wb_hold,
  output logic [CW-1:0]         buf_count
);

  localparam int EW = REG_ADDR_W + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0]         head;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  pipe_owns;
  logic                  bypass;
  logic [31:0]           busy;
  logic [31:0]           busy_nxt;
  logic [SW-1:0]         starve;
  logic [SW-1:0]         starve_nxt;

  wb_result_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({lu_waddr, lu_wdata}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (buf_count)
  );

  assign {head_addr, head_data} = head;
  assign lu_ready = !fifo_full;
  assign stall    = busy[rs1] | busy[rs2] | busy[rd_dec];

  always_comb begin
    pipe_owns = pipe_wr_en && (pipe_waddr != '0);
`ifdef REGFILE_WB_BYPASS_EN
    bypass    = fifo_empty && !pipe_owns && lu_valid;
`else
    bypass    = 1'b0;
`endif
    pop       = !fifo_empty && !pipe_owns;
    push      = lu_valid && !fifo_full && !bypass;

    rf_wr_en = 1'b0;
    rf_waddr = pipe_waddr;
    rf_wdata = pipe_wdata;
    if (pipe_owns) begin
      rf_wr_en = 1'b1;
    end else if (!fifo_empty) begin
      rf_wr_en = (head_addr != '0);
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end else if (bypass) begin
      rf_wr_en = (lu_waddr != '0);
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end
  end

  // Issue is applied after the clears so a same-cycle set wins
  always_comb begin
    busy_nxt = busy;
    if (pop)      busy_nxt[head_addr]   = 1'b0;
    if (bypass)   busy_nxt[lu_waddr]    = 1'b0;
    if (lu_issue) busy_nxt[lu_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;

    if (fifo_empty || pop)                starve_nxt = '0;
    else if (starve != SW'(STARVE_LIMIT)) starve_nxt = starve + SW'(1);
    else                                  starve_nxt = starve;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy    <= '0;
      starve  <= '0;
      wb_hold <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      starve  <= starve_nxt;
      wb_hold <= (starve_nxt == SW'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_wr_en;
  logic [4:0]      pipe_waddr;
  logic [XLEN-1:0] pipe_wdata;
  logic            lu_issue;
  logic [4:0]      lu_issue_rd;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_waddr;
  logic [XLEN-1:0] lu_wdata;
  logic            rf_wr_en;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      rs1, rs2, rd_dec;
  logic            stall;
  logic            wb_hold;
  logic [1:0]      buf_count;

  regfile_wb_arbiter #(
    .XLEN(XLEN), .BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1(rs1), .rs2(rs2), .rd_dec(rd_dec),
    .stall(stall), .wb_hold(wb_hold), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  wb_req_t   q[$];
  bit [31:0] m_busy;
  int        m_starve;
  bit        m_hold;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    pipe_wr_en = 0; pipe_waddr = 0; pipe_wdata = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    rs1 = 0; rs2 = 0; rd_dec = 0;
  endtask

  // Called just after a negedge with inputs set; checks, advances the model, returns at the next negedge.
  task automatic cycle();
    bit owns, byp, popd, ee;
    logic [4:0] ea;
    logic [XLEN-1:0] ed;
    int n;
    wb_req_t e;
    #1;
    owns = pipe_wr_en && (pipe_waddr != 0);
    byp  = 0;
`ifdef REGFILE_WB_BYPASS_EN
    byp  = (q.size() == 0) && !owns && lu_valid;
`endif
    ee = 0; ea = 0; ed = 0;
    if (owns) begin
      ee = 1; ea = pipe_waddr; ed = pipe_wdata;
    end else if (q.size() > 0) begin
      ee = (q[0].addr != 0); ea = q[0].addr; ed = q[0].data;
    end else if (byp) begin
      ee = (lu_waddr != 0); ea = lu_waddr; ed = lu_wdata;
    end
    if (rst) begin
      check_val("lu_ready", lu_ready, q.size() < DEPTH);
      check_val("rf_wr_en", rf_wr_en, ee);
      if (ee) begin
        check_val("rf_waddr", rf_waddr, ea);
        check_val("rf_wdata", rf_wdata, ed);
      end
      check_val("stall", stall, m_busy[rs1] | m_busy[rs2] | m_busy[rd_dec]);
      check_val("buf_count", buf_count, q.size());
      check_val("wb_hold", wb_hold, m_hold);
    end
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_busy = 0; m_starve = 0; m_hold = 0;
    end else begin
      n    = q.size();
      popd = !owns && (n > 0);
      if (popd) begin
        m_busy[q[0].addr] = 0;
        void'(q.pop_front());
      end
      if (byp) m_busy[lu_waddr] = 0;
      if (lu_valid && (n < DEPTH) && !byp) begin
        e.en = 1; e.addr = lu_waddr; e.data = lu_wdata;
        q.push_back(e);
      end
      if (lu_issue) m_busy[lu_issue_rd] = 1;
      m_busy[0] = 0;
      if (n == 0 || popd)     m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      m_hold = (m_starve == LIMIT);
    end
    @(negedge clk);
  endtask

  initial begin
    bit seen_hold;
    int pct;
    rst = 0; idle();
    @(negedge clk);

    // reset with traffic present
    lu_valid = 1; lu_waddr = 6; lu_wdata = 32'h66;
    pipe_wr_en = 1; pipe_waddr = 5; pipe_wdata = 32'h5555;
    cycle(); cycle();
    idle(); rs1 = 5; rs2 = 6; rd_dec = 7;
    #1;
    check_val("rst_buf_count", buf_count, 0);
    check_val("rst_stall", stall, 0);
    check_val("rst_lu_ready", lu_ready, 1);
    check_val("rst_rf_wr_en", rf_wr_en, 0);
    check_val("rst_wb_hold", wb_hold, 0);
    cycle();
    rst = 1; idle(); pipe_wr_en = 1; pipe_waddr = 5; pipe_wdata = 32'hDEAD;
    #1;
    check_val("post_rst_wr_en", rf_wr_en, 1);
    check_val("post_rst_waddr", rf_waddr, 5);
    cycle();

    // pipeline priority over a pending FIFO entry
    idle(); lu_issue = 1; lu_issue_rd = 7; cycle();
    idle(); pipe_wr_en = 1; pipe_waddr = 3; pipe_wdata = 32'hAA;
    lu_valid = 1; lu_waddr = 7; lu_wdata = 32'h55; cycle();
    idle(); pipe_wr_en = 1; pipe_waddr = 3; pipe_wdata = 32'hAA; rs1 = 7;
    #1;
    check_val("prio_waddr", rf_waddr, 3);
    check_val("prio_count", buf_count, 1);
    check_val("prio_busy7", stall, 1);
    cycle();
    idle();
    #1;
    check_val("drain_waddr", rf_waddr, 7);
    check_val("drain_wdata", rf_wdata, 32'h55);
    cycle();
    idle(); rs1 = 7;
    #1;
    check_val("drain_count", buf_count, 0);
    check_val("drain_busy7", stall, 0);
    cycle();

    // scoreboard stall until the x9 pop; rd=0 never stalls
    idle(); lu_issue = 1; lu_issue_rd = 9; cycle();
    idle(); rs1 = 9;
    #1; check_val("sb_stall9", stall, 1);
    cycle();
    idle(); rs2 = 9; pipe_wr_en = 1; pipe_waddr = 2; pipe_wdata = 32'h22;
    lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h99; cycle();
    idle(); rd_dec = 9;
    #1; check_val("sb_pending9", stall, 1);
    cycle();
    idle(); rs1 = 9;
    #1; check_val("sb_clear9", stall, 0);
    cycle();
    idle(); lu_issue = 1; lu_issue_rd = 0; cycle();
    idle();
    #1; check_val("sb_x0", stall, 0);
    cycle();

    // full FIFO under continuous pipeline writes, then forced bubble
    seen_hold = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      pipe_wr_en = !m_hold; pipe_waddr = 1; pipe_wdata = 32'h1000 + i;
      lu_valid = 1;
      lu_waddr = (i < 2) ? 5'(10 + i) : 5'd12;
      lu_wdata = 32'hB00 + i;
      if (i == 1) lu_valid = 1;
      #1;
      if (i == 2) check_val("full_lu_ready", lu_ready, 0);
      if (wb_hold) seen_hold = 1;
      if (i >= 3 && lu_ready && q.size() < DEPTH) ; // accepted this cycle; model tracks it
      cycle();
      if (q.size() == DEPTH && i >= 6) lu_valid = 0;
    end
    check_val("starve_hold_seen", seen_hold, 1);
    for (int i = 0; i < 4; i++) begin idle(); cycle(); end
    idle(); #1; check_val("full_drained", buf_count, 0);
    cycle();

    // same-cycle pop and re-issue of x12: set wins
    idle(); pipe_wr_en = 1; pipe_waddr = 2; lu_valid = 1; lu_waddr = 12; lu_wdata = 32'hC;
    cycle();
    idle(); lu_issue = 1; lu_issue_rd = 12; cycle();
    idle(); rs1 = 12;
    #1; check_val("setwins_busy12", stall, 1);
    cycle();
    idle(); pipe_wr_en = 1; pipe_waddr = 2; lu_valid = 1; lu_waddr = 12; cycle();
    idle(); cycle();

    // result arriving with FIFO empty and port idle
    idle(); lu_valid = 1; lu_waddr = 4; lu_wdata = 32'h1234;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check_val("byp_wr_en", rf_wr_en, 1);
    check_val("byp_waddr", rf_waddr, 4);
    check_val("byp_wdata", rf_wdata, 32'h1234);
`else
    check_val("nobyp_wr_en", rf_wr_en, 0);
`endif
    cycle();
    idle();
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check_val("byp_count", buf_count, 0);
`else
    check_val("nobyp_count", buf_count, 1);
`endif
    cycle();

    // randomised traffic with varying pipeline load and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0: pct = 30;
        1: pct = 70;
        2: pct = 90;
        default: pct = 50;
      endcase
      rst         = (i != 250);
      pipe_wr_en  = m_hold ? 1'b0 : ($urandom_range(0, 99) < pct);
      pipe_waddr  = 5'($urandom_range(0, 31));
      pipe_wdata  = $urandom;
      lu_valid    = ($urandom_range(0, 1) == 1);
      lu_waddr    = 5'($urandom_range(0, 15));
      lu_wdata    = $urandom;
      lu_issue    = ($urandom_range(0, 9) < 3);
      lu_issue_rd = 5'($urandom_range(0, 15));
      rs1         = 5'($urandom_range(0, 15));
      rs2         = 5'($urandom_range(0, 15));
      rd_dec      = 5'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
